// File: rtl/sm2201_mux_pkg.sv
// Shared types and constants for the SM2201 mux/storage register arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm2201_mux_pkg;

    // Counter width: holds SETTLE_CYCLES-1 (max 14) and LATCH_WIDTH-1 (max 6).
    localparam int CNT_W = 4;

    // Word-select / ownership encoding of the 74LS298-style register.
    localparam logic SRC_S1 = 1'b0;
    localparam logic SRC_S2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STROBE = 2'd2,
        ACK    = 2'd3
    } state_t;

endpackage

// File: rtl/sm2201_cycle_timer.sv
// Loadable down-counter with a zero flag; paces the SETTLE and STROBE phases.
// Latency: load/decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; the counter stops at zero rather than wrapping.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val on the next edge (has priority over dec)
//   load_val    value to load
//   dec         decrement on the next edge (ignored at zero)
//   zero        count is zero
module sm2201_cycle_timer
    import sm2201_mux_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sm2201_mux_reg_arbiter.sv
// Arbitrates two requesters onto one quad 2-input mux/storage register: select, settle, strobe, ack.
// Latency: ws valid after grant edge E0, latch after E0+SETTLE_CYCLES, ack after E0+SETTLE_CYCLES+LATCH_WIDTH.
// Backpressure: requesters hold req until their one-cycle ack; a loser simply waits for the next IDLE pass.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req1, req2      load requests for the s1 / s2 word (level, held until ack)
//   ack1, ack2      one-cycle pulse: s1 / s2 word latched
//   ws              word select to register (0 = s1, 1 = s2); also records the current winner
//   latch           latch strobe to register
//   busy            FSM not in IDLE
//   q_owner         source currently held in the register
//   q_valid         register holds an acknowledged load since reset
// Build option: define MUX_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests;
// otherwise req1 has fixed priority.
module sm2201_mux_reg_arbiter
    import sm2201_mux_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LATCH_WIDTH   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req1,
    input  logic req2,
    output logic ack1,
    output logic ack2,
    output logic ws,
    output logic latch,
    output logic busy,
    output logic q_owner,
    output logic q_valid
);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
        $error("sm2201_mux_reg_arbiter: SETTLE_CYCLES=%0d outside 1..15", SETTLE_CYCLES);
    end
    if ((LATCH_WIDTH < 1) || (LATCH_WIDTH > 7)) begin : g_bad_latch
        $error("sm2201_mux_reg_arbiter: LATCH_WIDTH=%0d outside 1..7", LATCH_WIDTH);
    end

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LD  = CNT_W'(LATCH_WIDTH - 1);

    state_t            state_q, state_d;
    logic              ws_d;
    logic              pick;
    logic              win_req;
    logic              q_upd;
    logic              t_load, t_dec, t_zero;
    logic [CNT_W-1:0]  t_val;

    sm2201_cycle_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    // pick is only consulted when at least one request is high, so !req1
    // selects s2 exactly when req2 is the sole requester.
`ifdef MUX_ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SRC_S1;
        end else if (state_q == ACK) begin
            rr_ptr <= ~ws;
        end
    end

    assign pick = (req1 && req2) ? rr_ptr : !req1;
`else
    assign pick = !req1;
`endif

    // ws doubles as the winner register: it is written only when leaving IDLE.
    assign win_req = (ws == SRC_S2) ? req2 : req1;

    always_comb begin
        state_d = state_q;
        ws_d    = ws;
        t_load  = 1'b0;
        t_val   = '0;
        t_dec   = 1'b0;
        q_upd   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req1 || req2) begin
                    state_d = SETTLE;
                    ws_d    = pick;
                    t_load  = 1'b1;
                    t_val   = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (!win_req) begin
                    state_d = IDLE;
                end else if (t_zero) begin
                    state_d = STROBE;
                    t_load  = 1'b1;
                    t_val   = LATCH_LD;
                end else begin
                    t_dec = 1'b1;
                end
            end
            STROBE: begin
                // No abort here: the register may already be capturing.
                if (t_zero) begin
                    state_d = ACK;
                    q_upd   = 1'b1;
                end else begin
                    t_dec = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ws      <= SRC_S1;
            q_owner <= SRC_S1;
            q_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            ws      <= ws_d;
            if (q_upd) begin
                q_owner <= ws;
                q_valid <= 1'b1;
            end
        end
    end

    assign latch = (state_q == STROBE);
    assign busy  = (state_q != IDLE);
    assign ack1  = (state_q == ACK) && (ws == SRC_S1);
    assign ack2  = (state_q == ACK) && (ws == SRC_S2);

endmodule
